// File: rtl/odd_parity_frame_tx_if.sv
// Word-level handshake and serial-line bundle for odd_parity_frame_tx.
// Optional macro ODD_PARITY_ERR_INJECT_EN adds the inject_err request line.
interface odd_parity_frame_tx_if #(
    parameter int N = 4
);
    logic [N-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         tx_out;
    logic         busy;
    logic         parity_out;
    logic         frame_done;
`ifdef ODD_PARITY_ERR_INJECT_EN
    logic         inject_err;
`endif

    // Producer / line observer side
    modport master (
`ifdef ODD_PARITY_ERR_INJECT_EN
        output inject_err,
`endif
        output data_in, data_valid,
        input  data_ready, tx_out, busy, parity_out, frame_done
    );

    // Transmitter side
    modport slave (
`ifdef ODD_PARITY_ERR_INJECT_EN
        input  inject_err,
`endif
        input  data_in, data_valid,
        output data_ready, tx_out, busy, parity_out, frame_done
    );
endinterface

// File: rtl/odd_parity_frame_tx.sv
// Odd-parity framed serial transmitter: START(0), N data bits LSB-first,
// odd parity bit, STOP(1). One word captured per valid/ready transfer.
// Optional macro ODD_PARITY_ERR_INJECT_EN: inject_err inverts the sent
// parity bit of the captured frame while parity_out stays correct.
module odd_parity_frame_tx #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    odd_parity_frame_tx_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_shift;
    logic [CW-1:0]   r_cnt;
    logic            r_parity;
    logic            r_par_tx;
    logic            w_ready;
    logic            w_xfer;
    logic            w_par_tx;
    logic            w_tx;
    logic            w_last_bit;

    function automatic logic odd_parity(input logic [N-1:0] d);
        return ~^d;
    endfunction

    assign w_ready    = ((r_state == S_IDLE) || (r_state == S_STOP)) && !rst;
    assign w_xfer     = bus.data_valid && w_ready;
    assign w_last_bit = (r_cnt == CW'(N - 1));

`ifdef ODD_PARITY_ERR_INJECT_EN
    assign w_par_tx = odd_parity(bus.data_in) ^ bus.inject_err;
`else
    assign w_par_tx = odd_parity(bus.data_in);
`endif

    // State, bit counter, shift register and parity capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
            r_par_tx <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_shift  <= bus.data_in;
                r_parity <= odd_parity(bus.data_in);
                r_par_tx <= w_par_tx;
            end else if (r_state == S_DATA) begin
                r_shift <= r_shift >> 1;
            end
            if (r_state == S_DATA && !w_last_bit) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Next-state sequencing of the frame
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer) w_next = S_START;
            S_START:  w_next = S_DATA;
            S_DATA:   if (w_last_bit) w_next = S_PARITY;
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = w_xfer ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Line level decoded purely from registered state
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shift[0];
            S_PARITY: w_tx = r_par_tx;
            default:  w_tx = 1'b1;
        endcase
    end

    assign bus.data_ready = w_ready;
    assign bus.tx_out     = w_tx;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = (r_state == S_STOP);
    assign bus.parity_out = r_parity;
endmodule

// File: tb/tb_odd_parity_frame_tx.sv
// Scoreboard bench for odd_parity_frame_tx (N=4): stimulus pushes the
// expected per-cycle line/flag values, a negedge monitor pops and compares.
module tb_odd_parity_frame_tx;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    odd_parity_frame_tx_if #(.N(N)) bus ();
    odd_parity_frame_tx #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic tx;
        logic fd;
        logic par;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   fd_count = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every busy cycle consumes one expected entry
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_done) fd_count++;
            if (bus.busy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy: busy=1 with nothing expected at %0t", $time);
                end else begin
                    mon_e = q.pop_front();
                    chk("tx_out", bus.tx_out, mon_e.tx);
                    chk("frame_done", bus.frame_done, mon_e.fd);
                    chk("parity_out", bus.parity_out, mon_e.par);
                end
            end else begin
                chk("idle_tx_out", bus.tx_out, 1'b1);
                chk("idle_frame_done", bus.frame_done, 1'b0);
            end
        end
    end

    task automatic push_frame(input logic [N-1:0] w, input logic inj);
        logic p;
        p = ~^w;
        q.push_back('{tx: 1'b0, fd: 1'b0, par: p});
        for (int i = 0; i < N; i++) q.push_back('{tx: w[i], fd: 1'b0, par: p});
        q.push_back('{tx: p ^ inj, fd: 1'b0, par: p});
        q.push_back('{tx: 1'b1, fd: 1'b1, par: p});
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!bus.data_ready && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!bus.data_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: data_ready=0 after 50 cycles");
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((q.size() != 0 || bus.busy) && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (q.size() != 0 || bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: queue=%0d busy=%b", q.size(), bus.busy);
        end
    endtask

    // Transfer one word; START must be on the line the cycle after the edge
    task automatic send(input logic [N-1:0] w, input logic inj, input logic keep_valid);
        wait_ready();
        bus.data_in    = w;
        bus.data_valid = 1'b1;
`ifdef ODD_PARITY_ERR_INJECT_EN
        bus.inject_err = inj;
`endif
        push_frame(w, inj);
        @(posedge clk);
        #1;
        chk("start_busy", bus.busy, 1'b1);
        chk("start_tx", bus.tx_out, 1'b0);
        if (!keep_valid) bus.data_valid = 1'b0;
`ifdef ODD_PARITY_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
    endtask

    initial begin
        logic [15:0] par_tbl;
        int          fd0;
        int          last_hs;
        par_tbl = 16'h9669;

        rst            = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
`ifdef ODD_PARITY_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_out", bus.tx_out, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_parity_out", bus.parity_out, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_data_ready", bus.data_ready, 1'b0);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_tx", bus.tx_out, 1'b1);
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_ready", bus.data_ready, 1'b1);
            chk("idle_fd", bus.frame_done, 1'b0);
        end

        // Single word 1011: line 0,1,1,0,1,0,1
        fd0 = fd_count;
        send(4'b1011, 1'b0, 1'b0);
        wait_idle();
        chk("single_parity_out", bus.parity_out, 1'b0);
        chk_int("single_fd_pulses", fd_count - fd0, 1);

        // Back-to-back 0..15 with data_valid held high
        fd0 = fd_count;
        last_hs = 0;
        for (int i = 0; i < 16; i++) begin
            wait_ready();
            if (i > 0) chk_int("b2b_frame_period", cyc - last_hs, 7);
            last_hs = cyc;
            bus.data_in    = 4'(i);
            bus.data_valid = 1'b1;
            push_frame(4'(i), 1'b0);
            @(posedge clk);
            #1;
            chk("b2b_start_tx", bus.tx_out, 1'b0);
            chk("b2b_parity_tbl", bus.parity_out, par_tbl[i]);
        end
        bus.data_valid = 1'b0;
        wait_idle();
        chk_int("b2b_fd_pulses", fd_count - fd0, 16);

        // Word offered during DATA is held off until STOP
        send(4'b1010, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.data_in    = 4'b0001;
        bus.data_valid = 1'b1;
        push_frame(4'b0001, 1'b0);
        for (int c = 0; c < 20 && !bus.frame_done; c++) begin
            chk("holdoff_ready", bus.data_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("stop_frame_done", bus.frame_done, 1'b1);
        chk("stop_ready", bus.data_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("holdoff_start_busy", bus.busy, 1'b1);
        chk("holdoff_start_tx", bus.tx_out, 1'b0);
        bus.data_valid = 1'b0;
        wait_idle();

        // Reset during DATA bit 2 of 1111 aborts the frame at once
        send(4'b1111, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_tx_out", bus.tx_out, 1'b1);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_frame_done", bus.frame_done, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_parity_out", bus.parity_out, 1'b0);
        send(4'b0000, 1'b0, 1'b0);
        wait_idle();
        chk("after_abort_parity", bus.parity_out, 1'b1);

`ifdef ODD_PARITY_ERR_INJECT_EN
        // Inverted parity bit on the line, correct parity_out
        send(4'b0000, 1'b1, 1'b0);
        wait_idle();
        send(4'b0000, 1'b0, 1'b0);
        wait_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
